ksa_init_engine: RTL and testbench

Parametrised successor to the fixed 256-entry identity initialiser of the RC4 datapath. It drives a single-port synchronous state RAM (one-cycle read latency, altsyncram-style) and either fills it with the identity permutation, runs the RC4 key-scheduling swap pass over it, or does both back-to-back. It sits between the top-level control and the `s` memory, ahead of the PRGA stage, and uses the lab-standard `en`/`rdy` handshake.

---
 rtl/ksa_init_engine_if.sv | 28 ++
 rtl/ksa_init_engine.sv | 149 ++++++++++++++
 tb/tb_ksa_init_engine.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ksa_init_engine_if.sv
// Handshake and state-RAM bus of the ksa_init_engine.
// master: controller plus RAM side (drives en/mode/key and the RAM read data).
// slave:  the engine itself.
interface ksa_init_engine_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = ADDR_W,
    parameter int KEY_LEN = 3
);
    logic                      en;
    logic                      rdy;
    logic                      done;
    logic [1:0]                mode;
    logic [KEY_LEN*DATA_W-1:0] key;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wrdata;
    logic                      wren;
    logic [DATA_W-1:0]         rddata;

    modport master (
        output en, mode, key, rddata,
        input  rdy, done, addr, wrdata, wren
    );

    modport slave (
        input  en, mode, key, rddata,
        output rdy, done, addr, wrdata, wren
    );
endinterface

// File: rtl/ksa_init_engine.sv
// RC4 state initialiser: identity fill and/or key-scheduling swap pass over a
// single-port synchronous RAM with one-cycle read latency.
module ksa_init_engine #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = ADDR_W,
    parameter int KEY_LEN = 3
) (
    input logic               clk,
    input logic               rst,
    ksa_init_engine_if.slave  bus
);
    localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, FILL, RD_I, WAIT_I, RD_J, WAIT_J, WR_J, WR_I, FIN
    } state_t;

    state_t                    state;
    logic [ADDR_W-1:0]         i;
    logic [ADDR_W-1:0]         j;
    logic [KIDX_W-1:0]         kidx;
    logic [DATA_W-1:0]         si;
    logic [DATA_W-1:0]         sj;
    logic [1:0]                mode_r;
    logic [KEY_LEN*DATA_W-1:0] key_r;
    logic [DATA_W-1:0]         key_elem;
    logic [ADDR_W-1:0]         j_new;

    // Select the current key element (element 0 sits in the MSBs) and form
    // the next j from the S[i] value arriving on rddata.
    always_comb begin
        key_elem = '0;
        for (int unsigned k = 0; k < KEY_LEN; k++) begin
            if (kidx == KIDX_W'(k)) begin
                key_elem = key_r[(KEY_LEN-1-k)*DATA_W +: DATA_W];
            end
        end
        j_new = j + bus.rddata + key_elem;
    end

    // Sequencer; every RAM-facing output is registered for the state being
    // entered, so addr/wrdata/wren always describe the current state's access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            kidx       <= '0;
            si         <= '0;
            sj         <= '0;
            mode_r     <= '0;
            key_r      <= '0;
            bus.rdy    <= 1'b1;
            bus.done   <= 1'b0;
            bus.wren   <= 1'b0;
            bus.addr   <= '0;
            bus.wrdata <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state   <= IDLE;
                    bus.rdy <= 1'b1;
                    if (bus.en) begin
                        mode_r   <= bus.mode;
                        key_r    <= bus.key;
                        i        <= '0;
                        j        <= '0;
                        kidx     <= '0;
                        bus.rdy  <= 1'b0;
                        bus.addr <= '0;
                        if (bus.mode == 2'b10) begin
                            state    <= RD_I;
                            bus.wren <= 1'b0;
                        end else begin
                            state      <= FILL;
                            bus.wrdata <= '0;
                            bus.wren   <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (i == '1) begin
                        i        <= '0;
                        bus.wren <= 1'b0;
                        bus.addr <= '0;
                        if (mode_r == 2'b01) begin
                            state <= RD_I;
                            j     <= '0;
                            kidx  <= '0;
                        end else begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                            bus.rdy  <= 1'b1;
                        end
                    end else begin
                        i          <= i + ADDR_W'(1);
                        bus.addr   <= i + ADDR_W'(1);
                        bus.wrdata <= i + ADDR_W'(1);
                    end
                end
                RD_I: begin
                    state <= WAIT_I;
                end
                // j is computed straight from rddata here so that the
                // registered addr already shows j_new during RD_J.
                WAIT_I: begin
                    si       <= bus.rddata;
                    j        <= j_new;
                    bus.addr <= j_new;
                    state    <= RD_J;
                end
                RD_J: begin
                    state <= WAIT_J;
                end
                WAIT_J: begin
                    sj         <= bus.rddata;
                    bus.addr   <= j;
                    bus.wrdata <= si;
                    bus.wren   <= 1'b1;
                    state      <= WR_J;
                end
                WR_J: begin
                    bus.addr   <= i;
                    bus.wrdata <= sj;
                    state      <= WR_I;
                end
                WR_I: begin
                    bus.wren <= 1'b0;
                    if (i == '1) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                        bus.rdy  <= 1'b1;
                    end else begin
                        i        <= i + ADDR_W'(1);
                        bus.addr <= i + ADDR_W'(1);
                        kidx     <= (kidx == KIDX_W'(KEY_LEN-1)) ? '0 : kidx + KIDX_W'(1);
                        state    <= RD_I;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.wren <= 1'b0;
                    bus.rdy  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ksa_init_engine.sv
// Directed bench for ksa_init_engine: an 8-bit/3-key instance and a 2-bit/1-key
// instance, each attached to its own behavioural single-port RAM.
module tb_ksa_init_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    ksa_init_engine_if #(.ADDR_W(8), .DATA_W(8), .KEY_LEN(3)) b8 ();
    ksa_init_engine_if #(.ADDR_W(2), .DATA_W(2), .KEY_LEN(1)) b2 ();

    ksa_init_engine #(.ADDR_W(8), .DATA_W(8), .KEY_LEN(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    ksa_init_engine #(.ADDR_W(2), .DATA_W(2), .KEY_LEN(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    logic [7:0] mem8 [256];
    logic [1:0] mem2 [4];
    logic [7:0] ms   [256];
    logic [1:0] exp_small [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    always #5 clk = ~clk;

    // Single-port RAM, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (b8.wren) mem8[b8.addr] <= b8.wrdata;
        b8.rddata <= mem8[b8.addr];
    end

    // Same RAM model for the small instance.
    always @(posedge clk) begin
        if (b2.wren) mem2[b2.addr] <= b2.wrdata;
        b2.rddata <= mem2[b2.addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_identity();
        for (int k = 0; k < 256; k++) ms[k] = 8'(k);
    endtask

    // Reference RC4 key schedule applied in place to ms.
    task automatic model_ksa(input logic [23:0] k);
        logic [7:0] jj, t, ke;
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            case (n % 3)
                0:       ke = k[23:16];
                1:       ke = k[15:8];
                default: ke = k[7:0];
            endcase
            jj = jj + ms[n] + ke;
            t = ms[n];
            ms[n] = ms[jj];
            ms[jj] = t;
        end
    endtask

    task automatic cmp_mem(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem8[k] !== ms[k]) bad++;
        check(tag, bad, 0);
    endtask

    // Start an operation on the 8-bit instance; cycle 1 is observed right
    // after the accepting edge. Optional mid-run en poke and reset abort.
    task automatic run8(input logic [1:0] m, input logic [23:0] k, input int poke_cyc,
                        input int rst_cyc, output int done_cyc, output int nwr,
                        output logic rdy1, output logic wren_at_rst);
        int cyc;
        @(negedge clk);
        b8.en = 1'b1; b8.mode = m; b8.key = k;
        @(posedge clk); #1;
        b8.en = 1'b0;
        cyc = 1; nwr = 0; done_cyc = -1; rdy1 = 1'bx; wren_at_rst = 1'bx;
        while (cyc < 4000) begin
            if (cyc == 1) rdy1 = b8.rdy;
            if (b8.wren) nwr++;
            if (b8.done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == rst_cyc) begin
                wren_at_rst = b8.wren;
                rst = 1'b1;
                break;
            end
            if (cyc == poke_cyc) begin
                b8.en = 1'b1; b8.mode = 2'b01; b8.key = 24'hFFFFFF;
            end else begin
                b8.en = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b8.en = 1'b0;
    endtask

    initial begin
        int dc, nw, cyc, ndone;
        logic r1, wr;

        b8.en = 1'b0; b8.mode = 2'b00; b8.key = '0;
        b2.en = 1'b0; b2.mode = 2'b00; b2.key = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", b8.rdy, 1);
        check("rst_done", b8.done, 0);
        check("rst_wren", b8.wren, 0);
        check("rst_addr", b8.addr, 0);
        check("rst_wrdata", b8.wrdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Mode 00: identity fill
        run8(2'b00, 24'h000000, -1, -1, dc, nw, r1, wr);
        check("m00_rdy_c1", r1, 0);
        check("m00_done_cyc", dc, 257);
        check("m00_rdy_done", b8.rdy, 1);
        check("m00_writes", nw, 256);
        model_identity();
        cmp_mem("m00_mem");

        // Mode 01 back-to-back with key 00033C
        run8(2'b01, 24'h00033C, -1, -1, dc, nw, r1, wr);
        check("m01_rdy_c1", r1, 0);
        check("m01_done_cyc", dc, 1793);
        check("m01_writes", nw, 768);
        model_identity();
        model_ksa(24'h00033C);
        cmp_mem("m01_mem");

        // Mode 10 over the previous result
        run8(2'b10, 24'h00033C, -1, -1, dc, nw, r1, wr);
        check("m10_done_cyc", dc, 1537);
        check("m10_writes", nw, 512);
        model_ksa(24'h00033C);
        cmp_mem("m10_mem");

        // Mode 01 with en/mode/key disturbed mid-run
        run8(2'b01, 24'h00033C, 300, -1, dc, nw, r1, wr);
        check("poke_done_cyc", dc, 1793);
        model_identity();
        model_ksa(24'h00033C);
        cmp_mem("poke_mem");

        // Mode 11 behaves as mode 00
        run8(2'b11, 24'h123456, -1, -1, dc, nw, r1, wr);
        check("m11_done_cyc", dc, 257);
        check("m11_writes", nw, 256);
        model_identity();
        cmp_mem("m11_mem");

        // Small instance: ADDR_W=2, key 0, mode 01
        @(negedge clk);
        b2.en = 1'b1; b2.mode = 2'b01; b2.key = '0;
        @(posedge clk); #1;
        b2.en = 1'b0;
        cyc = 1; dc = -1;
        while (cyc < 200) begin
            if (b2.done) begin
                dc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("small_done_cyc", dc, 29);
        for (int k = 0; k < 4; k++) check($sformatf("small_mem%0d", k), mem2[k], exp_small[k]);

        // Reset at cycle 100 of a mode-01 run
        run8(2'b01, 24'h00033C, -1, 100, dc, nw, r1, wr);
        check("abort_no_early_done", dc, -1);
        check("abort_wren_before", wr, 1);
        @(posedge clk); #1;
        check("abort_wren", b8.wren, 0);
        check("abort_rdy", b8.rdy, 1);
        check("abort_done", b8.done, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b8.done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Fresh mode 00 after the abort
        run8(2'b00, 24'h000000, -1, -1, dc, nw, r1, wr);
        check("post_done_cyc", dc, 257);
        model_identity();
        cmp_mem("post_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
